mul_sequencer: RTL and testbench

Iterative shift-add multiplier controller for the MUL path of the datapath. It latches two operands on Start and runs one partial-product step per cycle for WIDTH cycles, with a fixed latency. While it runs it drives Stall, which holds the fetch/decode/execute stages. When finished it presents the full 2·WIDTH-bit product with a one-cycle Done pulse, and the register-file write (MemToReg=1 path) takes ResultLo.

---
 rtl/mul_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier controller for the MUL path.
// It latches operands on i_start, runs one partial-product step per cycle for
// WIDTH cycles, then pulses o_done for one cycle with the 2*WIDTH-bit product.
// While it works it holds the pipeline through o_stall.
//
// Optional feature macro: MUL_SIGNED_EN
//   defined   -> i_signed=1 multiplies two's-complement operands (magnitudes are
//                multiplied, the product is negated on the final load if needed)
//   undefined -> i_signed is ignored, operands are always unsigned
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_start      multiply request (held by the stalled instruction)
//   i_operand_a  multiplicand (rs)
//   i_operand_b  multiplier (rt)
//   i_signed     two's-complement select (MUL_SIGNED_EN builds only)
//   o_stall      combinational pipeline hold
//   o_busy       registered, high in RUN
//   o_done       registered, one-cycle pulse in DONE
//   o_result_lo  product bits [WIDTH-1:0]
//   o_result_hi  product bits [2*WIDTH-1:WIDTH]
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_signed,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t               r_state, w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_res_lo, r_res_hi;
    logic                 r_busy, r_done;

    logic                 w_last;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_ld_a, w_ld_b;

    assign w_last     = (r_cnt == CNT_W'(WIDTH-1));
    // Partial-product step; carry out of 2*WIDTH bits is dropped.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MUL_SIGNED_EN
    logic r_sign;
    logic w_neg_a, w_neg_b;

    assign w_neg_a = i_signed & i_operand_a[WIDTH-1];
    assign w_neg_b = i_signed & i_operand_b[WIDTH-1];
    // Magnitude of the most negative value still fits as an unsigned WIDTH word.
    assign w_ld_a  = w_neg_a ? (~i_operand_a + 1'b1) : i_operand_a;
    assign w_ld_b  = w_neg_b ? (~i_operand_b + 1'b1) : i_operand_b;
    assign w_prod  = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sign <= 1'b0;
        else if (r_state == IDLE && i_start)
            r_sign <= w_neg_a ^ w_neg_b;
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = i_signed;
    assign w_ld_a          = i_operand_a;
    assign w_ld_b          = i_operand_b;
    assign w_prod          = w_acc_next;
`endif

    // State register plus registered status flags derived from next state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == RUN);
            r_done  <= (w_next_state == DONE);
        end
    end

    // Next-state logic. DONE ignores i_start: the same instruction is still
    // presenting it while it advances out of the stall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            IDLE:    o_stall = i_start;
            RUN:     o_stall = 1'b1;
            default: o_stall = 1'b0;
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result_lo = r_res_lo;
    assign o_result_hi = r_res_hi;

    // Datapath. Results are only written on the final step, so they survive
    // a new Start until the next multiply completes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_ld_a};
                        r_mplier <= w_ld_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res_lo <= w_prod[WIDTH-1:0];
                        r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

`ifdef MUL_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] opa, opb;
    logic        sgn_in;
    logic        stall, busy, done;
    logic [31:0] res_lo, res_hi;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic        prev_done = 1'b0;

    mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_operand_a (opa),
        .i_operand_b (opb),
        .i_signed    (sgn_in),
        .o_stall     (stall),
        .o_busy      (busy),
        .o_done      (done),
        .o_result_lo (res_lo),
        .o_result_hi (res_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none pending");
            end else begin
                chk("product", {res_hi, res_lo}, exp_q.pop_front());
            end
            if (prev_done) chk("done_one_cycle", 64'(prev_done & done), 64'd0);
        end
        prev_done <= done;
    end

    // One multiply from the next IDLE cycle through its Done cycle. Leaves the
    // bench sitting at the negedge of the DONE cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input bit hold, input bit scramble);
        int n_stall = 0, n_busy = 0, lat = -1;
        bit held_bad = 1'b0;
        logic [63:0] prev_res;
        @(negedge clk);
        start = 1'b1; opa = a; opb = b; sgn_in = s;
        exp_q.push_back(exp);
        #1;
        prev_res = {res_hi, res_lo};
        chk("no_done_at_issue", 64'(done), 64'd0);
        for (int c = 0; c < 60; c++) begin
            if (stall) n_stall++;
            if (busy)  n_busy++;
            if (done) begin lat = c; break; end
            if ({res_hi, res_lo} !== prev_res) held_bad = 1'b1;
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (scramble) begin opa = $urandom; opb = $urandom; sgn_in = 1'($urandom); end
            #1;
        end
        chk("latency", 64'(lat), 64'd33);
        chk("stall_cycles", 64'(n_stall), 64'd33);
        chk("busy_cycles", 64'(n_busy), 64'd32);
        chk("result_held", 64'(held_bad), 64'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{32'd6,          32'd7,          1'b0, 64'd42});
        tbl.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001});
        tbl.push_back('{32'hFFFF_FFFD,  32'd5,          1'b1,
                        SGN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1});
        tbl.push_back('{32'hFFFF_FFFD,  32'd5,          1'b0, 64'h0000_0004_FFFF_FFF1});
        tbl.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1,
                        SGN ? 64'd1 : 64'hFFFF_FFFE_0000_0001});
        tbl.push_back('{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000});
        tbl.push_back('{32'd0,          32'hDEAD_BEEF,  1'b0, 64'd0});
        tbl.push_back('{32'd1,          32'hFFFF_FFFF,  1'b0, 64'h0000_0000_FFFF_FFFF});
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            tbl.push_back('{ra, rb, 1'b0, {32'd0, ra} * {32'd0, rb}});
        end

        rst = 1'b1; start = 1'b0; opa = '0; opb = '0; sgn_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_busy",  64'(busy),  64'd0);
        chk("reset_done",  64'(done),  64'd0);
        chk("reset_result", {res_hi, res_lo}, 64'd0);

        foreach (tbl[i]) run_mul(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, 1'b0, 1'b0);

        // Operands wander during RUN; only the latched values matter.
        run_mul(32'd100, 32'd200, 1'b0, 64'd20000, 1'b0, 1'b1);
        opa = '0; opb = '0; sgn_in = 1'b0;

        // Start held through DONE: one pulse, then a new multiply right away.
        run_mul(32'd6, 32'd7, 1'b0, 64'd42, 1'b1, 1'b0);
        run_mul(32'd2, 32'd3, 1'b0, 64'd6, 1'b1, 1'b0);
        start = 1'b0;

        // Reset in RUN cycle 10: work is discarded without a Done pulse.
        @(negedge clk);
        start = 1'b1; opa = 32'd9; opb = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_busy",   64'(busy),  64'd0);
        chk("midrun_done",   64'(done),  64'd0);
        chk("midrun_stall",  64'(stall), 64'd0);
        chk("midrun_result", {res_hi, res_lo}, 64'd0);
        start = 1'b1;
        #1;
        chk("midrun_stall_start", 64'(stall), 64'd1);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrun_idle_busy", 64'(busy), 64'd0);

        // A normal multiply still works after the abort.
        run_mul(32'd12, 32'd12, 1'b0, 64'd144, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
